slowclk_tick_rx: RTL and testbench

SLOWCLK_TICK_RX -- requirements
Module: slowclk_tick_rx

---
 rtl/slowclk_rx_pkg.sv | 37 +++
 rtl/bit_sync.sv | 39 +++
 rtl/slowclk_tick_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_slowclk_tick_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/slowclk_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slowclk_rx_pkg
// Description : Shared definitions for the slow-clock tick receiver: the
//               receiver state encoding and the default values for the
//               synchronizer depth, loss timeout and lock edge count.
// Revision    : 1.0 - initial release
// ============================================================================
package slowclk_rx_pkg;

  // Default synchronizer depth (number of flops between the async input
  // and the first flop allowed to feed logic).
  localparam int c_def_sync_stages = 2;

  // Default loss timeout in CLOCK cycles (one second at 300 MHz).
  localparam int c_def_timeout     = 300000000;

  // Default number of consecutive in-time rising edges needed to lock.
  localparam int c_def_lock_edges  = 3;

  // Width of the edge counter; holds lock edge counts up to 15.
  localparam int c_ec_w            = 4;

  // Receiver state.
  //   ST_SEARCH  : nothing seen since reset or since acquisition failed
  //   ST_ACQUIRE : counting consecutive in-time rising edges
  //   ST_LOCKED  : slow clock present and regular
  //   ST_LOST    : slow clock vanished after having been locked
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } rx_state_t;

endpackage : slowclk_rx_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Single-bit multi-flop synchronizer bringing an asynchronous
//               level into the CLOCK domain. All flops clear asynchronously.
//
// Parameters  : STAGES   - number of flops in the chain (2 to 4)
//
// Ports       : CLOCK    - destination clock, rising edge
//               RESET    - asynchronous active-high reset, clears the chain
//               async_in - asynchronous level to be synchronized
//               sync_out - synchronized level, STAGES cycles after async_in
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic async_in,
  output logic sync_out
);

  // Flop chain; bit 0 is the metastability-catching flop, the top bit is
  // the first one considered safe to use.
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = r_chain[STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/slowclk_tick_rx.sv
`default_nettype none
// ============================================================================
// Module      : slowclk_tick_rx
// Description : Receives a slow, free-running clock that is asynchronous to
//               CLOCK. Produces a one-cycle TICK per rising edge, tracks
//               whether the slow clock is present and regular (LOCKED) or
//               has disappeared (LOST), and optionally measures its period.
//
// Parameters  : SYNC_STAGES - synchronizer depth, 2 to 4
//               CNT_W       - width of the period counter
//               TIMEOUT     - cycles without a rising edge that mean loss,
//                             2 to 2^CNT_W-1
//               LOCK_EDGES  - consecutive in-time rising edges to lock,
//                             2 to 15
//
// Ports       : CLOCK       - system clock, all logic on its rising edge
//               RESET       - asynchronous active-high reset
//               SLOWCLK_IN  - slow toggling clock, asynchronous to CLOCK
//               TICK        - one-cycle strobe per detected rising edge,
//                             SYNC_STAGES+1 cycles after the input rises
//               LOCKED      - high while the receiver is locked
//               LOST        - high while the slow clock is declared lost
//               PERIOD      - last rising-to-rising period in CLOCK cycles
//
// Build macro : SLOWCLK_TICK_RX_PERIOD_EN
//               defined   - PERIOD is a register updated on each rise that
//                           follows an earlier rise of the same acquisition
//               undefined - PERIOD is constant 0 and its register is absent;
//                           the cycle counter stays because the timeout
//                           depends on it
// Revision    : 1.0 - initial release
// ============================================================================
module slowclk_tick_rx
  import slowclk_rx_pkg::*;
#(
  parameter int SYNC_STAGES = c_def_sync_stages,
  parameter int CNT_W       = 29,
  parameter int TIMEOUT     = c_def_timeout,
  parameter int LOCK_EDGES  = c_def_lock_edges
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             SLOWCLK_IN,
  output logic             TICK,
  output logic             LOCKED,
  output logic             LOST,
  output logic [CNT_W-1:0] PERIOD
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0]  c_cnt_max    = '1;
  localparam logic [CNT_W-1:0]  c_timeout_m1 = CNT_W'(TIMEOUT - 1);
  localparam logic [c_ec_w-1:0] c_lock_edges = c_ec_w'(LOCK_EDGES);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic              w_synced;
  logic              r_prev;
  logic              w_rise;
  logic              r_tick;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  rx_state_t         r_state;
  logic [c_ec_w-1:0] r_ec;
  logic [c_ec_w-1:0] w_ec_next;
  logic              r_locked;
  logic              r_lost;

  // --------------------------------------------------------------------------
  // Input synchronizer and rising-edge detect
  // --------------------------------------------------------------------------
  bit_sync #(
    .STAGES   (SYNC_STAGES)
  ) u_sync (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .async_in (SLOWCLK_IN),
    .sync_out (w_synced)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_synced;
    end
  end

  // Because r_prev clears on reset, an input already high at reset release
  // is seen as one genuine rising edge.
  assign w_rise = w_synced & ~r_prev;

  // TICK is registered so it is glitch-free and fires in every state.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Cycle counter: cycles elapsed since the last rise cycle
  // --------------------------------------------------------------------------
  // Saturating increment. It doubles as the period value: a rise seen while
  // the counter holds N means N+1 cycles separate the two rise cycles.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  // The counter restarts on every entry into ACQUIRE or LOCKED, so in those
  // states it passes through TIMEOUT-1 exactly once per missing edge. The
  // inequality only matters for states that ignore the timeout.
  assign w_timeout = (r_cnt >= c_timeout_m1);

  // --------------------------------------------------------------------------
  // Lock / loss state machine with registered status outputs
  // --------------------------------------------------------------------------
  assign w_ec_next = r_ec + 1'b1;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_SEARCH;
      r_ec     <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_rise) begin
            r_state <= ST_ACQUIRE;
            r_ec    <= c_ec_w'(1);
          end
        end

        ST_ACQUIRE: begin
          // A rise always wins over a coincident timeout.
          if (w_rise) begin
            r_ec <= w_ec_next;
            if (w_ec_next >= c_lock_edges) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= ST_SEARCH;
            r_ec    <= '0;
          end
        end

        ST_LOCKED: begin
          if (!w_rise && w_timeout) begin
            r_state  <= ST_LOST;
            r_ec     <= '0;
            r_locked <= 1'b0;
            r_lost   <= 1'b1;
          end
        end

        ST_LOST: begin
          if (w_rise) begin
            r_state <= ST_ACQUIRE;
            r_ec    <= c_ec_w'(1);
            r_lost  <= 1'b0;
          end
        end

        default: begin
          r_state  <= ST_SEARCH;
          r_ec     <= '0;
          r_locked <= 1'b0;
          r_lost   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Period measurement
  // --------------------------------------------------------------------------
`ifdef SLOWCLK_TICK_RX_PERIOD_EN
  logic [CNT_W-1:0] r_period;

  // Only a rise that follows an earlier rise of the same acquisition carries
  // a meaningful interval; the first rise out of SEARCH or LOST does not.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_period <= '0;
    end else if (w_rise && ((r_state == ST_ACQUIRE) || (r_state == ST_LOCKED))) begin
      r_period <= w_cnt_inc;
    end
  end

  assign PERIOD = r_period;
`else
  assign PERIOD = '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign TICK   = r_tick;
  assign LOCKED = r_locked;
  assign LOST   = r_lost;

endmodule : slowclk_tick_rx
`default_nettype wire

// File: tb/tb_slowclk_tick_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_slowclk_tick_rx
// Description : Self-checking bench for slowclk_tick_rx with SYNC_STAGES=2,
//               CNT_W=8, TIMEOUT=50, LOCK_EDGES=3. Directed scenarios plus
//               randomized slow-clock waveforms, checked every cycle against
//               a behavioural model, with literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slowclk_tick_rx;

  localparam int SS   = 2;
  localparam int CW   = 8;
  localparam int TO   = 50;
  localparam int LE   = 3;
  localparam int CMAX = (1 << CW) - 1;

`ifdef SLOWCLK_TICK_RX_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          CLOCK      = 1'b0;
  logic          RESET      = 1'b0;
  logic          SLOWCLK_IN = 1'b0;
  logic          TICK;
  logic          LOCKED;
  logic          LOST;
  logic [CW-1:0] PERIOD;

  slowclk_tick_rx #(
    .SYNC_STAGES (SS),
    .CNT_W       (CW),
    .TIMEOUT     (TO),
    .LOCK_EDGES  (LE)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .SLOWCLK_IN (SLOWCLK_IN),
    .TICK       (TICK),
    .LOCKED     (LOCKED),
    .LOST       (LOST),
    .PERIOD     (PERIOD)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int tick_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. hist[k] is SLOWCLK_IN as sampled k clock edges ago.
  // A rise is "seen" SS edges after sampling and announced one edge later.
  // gap = cycles since the last rise was seen (saturating), mode/edges track
  // the lock rules.
  // --------------------------------------------------------------------------
  localparam int M_SEARCH = 0, M_ACQ = 1, M_LOCK = 2, M_LOST = 3;
  int hist[$];
  int gap, mode, edges, m_period;
  int e_tick, e_locked, e_lost;

  task automatic m_reset();
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back(0);
    gap = 0; mode = M_SEARCH; edges = 0; m_period = 0;
    e_tick = 0; e_locked = 0; e_lost = 0;
  endtask

  always @(posedge CLOCK or posedge RESET) begin : model
    bit rise;
    if (RESET) begin
      m_reset();
    end else begin
      rise = (hist[SS-1] == 1) && (hist[SS] == 0);
      e_tick = rise ? 1 : 0;
      if (rise) begin
        if (mode == M_ACQ || mode == M_LOCK)
          m_period = (gap + 1 > CMAX) ? CMAX : gap + 1;
        if (mode == M_SEARCH || mode == M_LOST) begin
          mode = M_ACQ; edges = 1;
        end else if (mode == M_ACQ) begin
          edges++;
          if (edges >= LE) mode = M_LOCK;
        end
        gap = 0;
      end else begin
        if (gap == TO - 1) begin
          if (mode == M_ACQ) begin mode = M_SEARCH; edges = 0; end
          else if (mode == M_LOCK) mode = M_LOST;
        end
        if (gap < CMAX) gap++;
      end
      e_locked = (mode == M_LOCK) ? 1 : 0;
      e_lost   = (mode == M_LOST) ? 1 : 0;
      hist.push_front(int'(SLOWCLK_IN));
      void'(hist.pop_back());
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("tick",   int'(TICK),   e_tick);
      chk("locked", int'(LOCKED), e_locked);
      chk("lost",   int'(LOST),   e_lost);
      chk("period", int'(PERIOD), PEN ? m_period : 0);
      chk("locked_and_lost", int'(LOCKED && LOST), 0);
      if (TICK) tick_cnt++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; all drives happen 2 ns after a rising edge
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #2;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      SLOWCLK_IN = 1'b1; step(hi);
      SLOWCLK_IN = 1'b0; step(lo);
    end
  endtask

  task automatic reset_pulse();
    RESET = 1'b1;
    #1;
    chk("rst_tick",   int'(TICK),   0);
    chk("rst_locked", int'(LOCKED), 0);
    chk("rst_lost",   int'(LOST),   0);
    chk("rst_period", int'(PERIOD), 0);
    step(2);
    RESET = 1'b0;
  endtask

  int t0;

  initial begin
    RESET = 1'b1;
    step(3);
    chk_en = 1'b1;
    reset_pulse();
    step(2);

    // Square wave, period 20: six rises, lock after the third.
    t0 = tick_cnt;
    wave(10, 10, 6);
    chk("sq20_ticks",  tick_cnt - t0, 6);
    chk("sq20_locked", int'(LOCKED), 1);
    chk("sq20_period", int'(PERIOD), PEN ? 20 : 0);

    // Rise seen exactly when the counter is at TIMEOUT-1: stays locked.
    wave(10, 40, 2);
    chk("edge50_locked", int'(LOCKED), 1);
    chk("edge50_lost",   int'(LOST),   0);
    chk("edge50_period", int'(PERIOD), PEN ? 50 : 0);

    // Slow clock stops: loss declared.
    step(60);
    chk("loss_lost",   int'(LOST),   1);
    chk("loss_locked", int'(LOCKED), 0);

    // Next rise leaves LOST (back to acquiring, not yet locked).
    SLOWCLK_IN = 1'b1; step(5);
    chk("relost_lost",   int'(LOST),   0);
    chk("relost_locked", int'(LOCKED), 0);

    // Second acquisition edge, then reset mid-acquisition.
    SLOWCLK_IN = 1'b0; step(10);
    SLOWCLK_IN = 1'b1; step(10);
    SLOWCLK_IN = 1'b0;
    reset_pulse();
    step(3);
    wave(10, 10, 2);
    chk("rstacq_two_rises_locked", int'(LOCKED), 0);
    wave(10, 10, 1);
    chk("rstacq_three_rises_locked", int'(LOCKED), 1);

    // Input already high at reset release: exactly one tick.
    SLOWCLK_IN = 1'b1;
    reset_pulse();
    t0 = tick_cnt;
    step(10);
    chk("high_at_release_ticks", tick_cnt - t0, 1);
    SLOWCLK_IN = 1'b0;

    // Period 300: every gap exceeds the timeout, never locks.
    reset_pulse();
    step(2);
    wave(150, 150, 3);
    chk("p300_locked", int'(LOCKED), 0);
    chk("p300_period", int'(PERIOD), 0);

    // Randomized slow-clock waveforms, occasionally with a reset.
    reset_pulse();
    for (int i = 0; i < 250; i++) begin
      wave(int'($urandom_range(1, 40)), int'($urandom_range(1, 60)), 1);
      if ($urandom_range(0, 49) == 0) reset_pulse();
    end
    step(10);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_slowclk_tick_rx
`default_nettype wire
